div_unit: RTL and testbench

- Multi-cycle 32-bit integer divider in the EX stage of the MIPS32 pipeline; implements DIV and DIVU.
- Operands come from the register-file read ports, routed through ID/EX.
- Produces a {remainder, quotient} pair for the HI/LO write path.
- Uses restoring division, one quotient bit per cycle. The pipeline stalls on ready_o low while a divide is in flight.

---
 rtl/div_unit.sv | 124 ++++++++++++
 tb/tb_div_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Restoring 32-bit DIV/DIVU, one quotient bit per cycle; {rem, quo} feeds HI/LO.
// Result is ready 33 edges after the accept edge (2 for divide-by-zero); the EX stage stalls until ready_o is high.
module div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   dvd;      // dividend shifts out MSB-first, quotient shifts in at LSB
  logic [DATA_W-1:0]   dvs;
  logic [DATA_W-1:0]   rem;
  logic [2*DATA_W-1:0] res;
  logic                sgn, s1, s2;

  logic [DATA_W:0]     shifted, diff;
  logic                qbit;
  logic [DATA_W-1:0]   rem_nxt, dvd_nxt, quo_fix, rem_fix, mag1, mag2;
  logic                accept, last_iter;

  assign accept    = start_i && !annul_i;
  assign last_iter = (cnt == CNT_W'(DATA_W - 1));

  always_comb begin
    mag1 = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    mag2 = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
  end

  // Partial remainder stays below the divisor, so DATA_W bits suffice between iterations
  always_comb begin
    shifted = {rem, dvd[DATA_W-1]};
    diff    = shifted - {1'b0, dvs};
    qbit    = ~diff[DATA_W];
    rem_nxt = qbit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
    dvd_nxt = {dvd[DATA_W-2:0], qbit};
    quo_fix = (sgn && (s1 ^ s2)) ? -dvd_nxt : dvd_nxt;
    rem_fix = (sgn && s1) ? -rem_nxt : rem_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (opdata2_i == '0) ? BYZERO : ON;
      BYZERO:  state_nxt = END;
      ON:      if (annul_i) state_nxt = IDLE;
               else if (last_iter) state_nxt = END;
      END:     if (!start_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      res      <= '0;
      sgn      <= 1'b0;
      s1       <= 1'b0;
      s2       <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (accept) begin
            sgn <= signed_div_i;
            s1  <= opdata1_i[DATA_W-1];
            s2  <= opdata2_i[DATA_W-1];
            if (opdata2_i != '0) begin
              dvd <= mag1;
              dvs <= mag2;
              rem <= '0;
              cnt <= '0;
            end
          end
        end
        BYZERO: res <= '0;
        ON: begin
          if (!annul_i) begin
            rem <= rem_nxt;
            dvd <= dvd_nxt;
            cnt <= cnt + 1'b1;
            if (last_iter) res <= {rem_fix, quo_fix};
          end
        end
        END: begin
          if (start_i) begin
            ready_o  <= 1'b1;
            result_o <= res;
          end else begin
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end
        default: begin
          ready_o  <= 1'b0;
          result_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: latency, results, handshake, annul and async reset.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_cmp = 0;
  int n_bad = 0;

  div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Start held until ready; operands are scrambled after the accept edge.
  task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input int elat,
                         input string nm);
    int lat;
    lat = 0;
    @(negedge clk);
    signed_div_i = sg;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    do begin
      @(posedge clk);
      lat++;
      if (lat == 1) begin
        #1;
        opdata1_i = $urandom;
        opdata2_i = $urandom;
      end
      @(negedge clk);
    end while (!ready_o && lat < 100);
    chk({nm, " latency"}, 64'(lat), 64'(elat));
    chk({nm, " result"}, result_o, {er, eq});
    start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({nm, " ready drop"}, 64'(ready_o), 64'd0);
    chk({nm, " result clear"}, result_o, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    int lat;

    vecs[0] = '{1'b0, 32'd100,        32'd7,        32'h0000000E, 32'h00000002, 34};
    vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 34};
    vecs[2] = '{1'b0, 32'd5,          32'd0,        32'h00000000, 32'h00000000, 3};
    vecs[3] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'h00000000, 34};
    vecs[4] = '{1'b0, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF, 32'h00000000, 34};
    vecs[5] = '{1'b1, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 34};
    vecs[6] = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 34};
    vecs[7] = '{1'b0, 32'hFFFFFFF9,   32'd2,        32'h7FFFFFFC, 32'h00000001, 34};
    vecs[8] = '{1'b1, 32'h12345678,   32'd0,        32'h00000000, 32'h00000000, 3};
    vecs[9] = '{1'b0, 32'd3,          32'd10,       32'h00000000, 32'h00000003, 34};

    rst          = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ready", 64'(ready_o), 64'd0);
    chk("reset result", result_o, 64'd0);
    rst = 1'b1;

    for (int i = 0; i < 10; i++)
      run_div(vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].lat,
              $sformatf("vec%0d", i));

    // annul in the middle of ON, then a normal divide
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    annul_i = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready_o) seen = 1'b1;
    end
    chk("annul no ready", 64'(seen), 64'd0);
    run_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 34, "after annul");

    // start and annul together in IDLE must not start a divide
    @(negedge clk);
    opdata1_i = 32'd9;
    opdata2_i = 32'd0;
    start_i   = 1'b1;
    annul_i   = 1'b1;
    repeat (5) @(negedge clk);
    chk("start+annul idle", 64'(ready_o), 64'd0);
    start_i = 1'b0;
    annul_i = 1'b0;

    // async reset between edges while dividing
    @(negedge clk);
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    start_i   = 1'b1;
    repeat (15) @(posedge clk);
    @(negedge clk);
    #2;
    rst     = 1'b0;
    start_i = 1'b0;
    #1;
    chk("mid-ON reset ready", 64'(ready_o), 64'd0);
    chk("mid-ON reset result", result_o, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    run_div(1'b0, 32'd15, 32'd4, 32'd3, 32'd3, 34, "after reset");

    // async reset while a result is being presented
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd50;
    opdata2_i    = 32'd6;
    start_i      = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ready_o && lat < 100);
    chk("END result before reset", result_o, {32'd2, 32'd8});
    #2;
    rst     = 1'b0;
    start_i = 1'b0;
    #1;
    chk("END reset ready", 64'(ready_o), 64'd0);
    chk("END reset result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
